// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/halt control with registered forwarding selects
//
// Ports:
//   clk, rst_n            pipeline clock, asynchronous active-low reset
//   bubble                load-use hazard: hold IF/ID and PC, insert NOP into ID/EX
//   dire[5:0]             forwarding detects ([0]/[1] EX/MEM, [2]/[3] MEM/WB, [4]/[5] EX/MEM load; even=RA, odd=RB)
//   mispredict            EX-stage branch resolved wrong: refetch and squash IF/ID and ID/EX
//   halt                  halt instruction in EX: freeze the pipeline
//   go                    resume from HALT (level, sampled each cycle)
//   pc_en, ifid_en        stage-register write enables
//   ifid_flush, idex_flush stage-register synchronous clears
//   fwd_a, fwd_b          EX-stage operand mux selects (0 regfile, 1 EX/MEM ALU, 2 MEM/WB, 3 EX/MEM load)
//   halted                high while in HALT
//   stall_cnt, flush_cnt  saturating event counters
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bubble,
    input  logic [5:0]       dire,
    input  logic             mispredict,
    input  logic             halt,
    input  logic             go,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t state;

    logic run_act;     // RUN and no halt request: mispredict/bubble may act
    logic do_flush;
    logic do_stall;
    logic advance;     // ID/EX boundary moves a real instruction forward
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    // Priority halt > mispredict > bubble; a mispredict squashes any bubble.
    always_comb begin
        run_act  = (state == ST_RUN) && !halt;
        do_flush = run_act && mispredict;
        do_stall = run_act && !mispredict && bubble;
        advance  = run_act && !mispredict && !bubble;

        pc_en      = advance || do_flush;
        ifid_en    = advance || do_flush;
        ifid_flush = do_flush;
        idex_flush = do_flush || do_stall;
    end

    // Load data from EX/MEM is the youngest producer; EX/MEM beats MEM/WB.
    always_comb begin
        sel_a = 2'd0;
        if (dire[4])      sel_a = 2'd3;
        else if (dire[0]) sel_a = 2'd1;
        else if (dire[2]) sel_a = 2'd2;

        sel_b = 2'd0;
        if (dire[5])      sel_b = 2'd3;
        else if (dire[1]) sel_b = 2'd1;
        else if (dire[3]) sel_b = 2'd2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            halted    <= 1'b0;
            fwd_a     <= 2'd0;
            fwd_b     <= 2'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (go) begin
                        state  <= ST_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_RUN;
                    halted <= 1'b0;
                end
            endcase

            // Selects follow the instruction into EX; a NOP carries no forwarding.
            if (advance) begin
                fwd_a <= sel_a;
                fwd_b <= sel_b;
            end else if (idex_flush) begin
                fwd_a <= 2'd0;
                fwd_b <= 2'd0;
            end

            if (do_stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (do_flush && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
